acs_unit: RTL and testbench

ACS_UNIT -- requirements
Module: acs_unit

---
 rtl/acs_unit.sv | 101 ++++++++++
 tb/tb_acs_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/acs_unit.sv
// acs_unit: one-symbol-per-cycle add-compare-select for the K=3 (7,5) Viterbi trellis
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            branch-metric handshake; start marks the first symbol of a frame
//   bm00..bm11                   Hamming distance of the received pair to each codeword
//   out_valid/out_ready          result handshake
//   dec                          survivor decision per next state (1 = odd predecessor)
//   pm0..pm3                     normalized path metrics after the symbol
//   best_state, sym_cnt          index of the zero metric, 1-based symbol index within the frame
module acs_unit #(
    parameter int PM_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    input  logic [1:0]       bm00,
    input  logic [1:0]       bm01,
    input  logic [1:0]       bm10,
    input  logic [1:0]       bm11,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       dec,
    output logic [PM_W-1:0]  pm0,
    output logic [PM_W-1:0]  pm1,
    output logic [PM_W-1:0]  pm2,
    output logic [PM_W-1:0]  pm3,
    output logic [1:0]       best_state,
    output logic [CNT_W-1:0] sym_cnt
);
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(16);

    logic [3:0][PM_W-1:0] pm_q, old_pm, cand_e, cand_o, raw, norm;
    logic [3:0]           dec_nxt;
    logic [PM_W-1:0]      min_lo, min_hi, min_all;
    logic [1:0]           best_nxt;
    logic                 accept;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return s[PM_W] ? '1 : s[PM_W-1:0];
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Next state n = {u, s1}: even predecessor is {n[0], 0}, odd is {n[0], 1}
    always_comb begin
        old_pm    = start ? {PM_INIT, PM_INIT, PM_INIT, PM_W'(0)} : pm_q;
        cand_e[0] = sat_add(old_pm[0], bm00);
        cand_o[0] = sat_add(old_pm[1], bm11);
        cand_e[1] = sat_add(old_pm[2], bm10);
        cand_o[1] = sat_add(old_pm[3], bm01);
        cand_e[2] = sat_add(old_pm[0], bm11);
        cand_o[2] = sat_add(old_pm[1], bm00);
        cand_e[3] = sat_add(old_pm[2], bm01);
        cand_o[3] = sat_add(old_pm[3], bm10);
        for (int i = 0; i < 4; i++) begin
            // ties keep the even predecessor
            dec_nxt[i] = cand_o[i] < cand_e[i];
            raw[i]     = dec_nxt[i] ? cand_o[i] : cand_e[i];
        end
        min_lo  = raw[0] < raw[1] ? raw[0] : raw[1];
        min_hi  = raw[2] < raw[3] ? raw[2] : raw[3];
        min_all = min_lo < min_hi ? min_lo : min_hi;
        for (int i = 0; i < 4; i++)
            norm[i] = raw[i] - min_all;
        best_nxt = norm[0] == '0 ? 2'd0 :
                   norm[1] == '0 ? 2'd1 :
                   norm[2] == '0 ? 2'd2 : 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q       <= {PM_INIT, PM_INIT, PM_INIT, PM_W'(0)};
            out_valid  <= 1'b0;
            dec        <= '0;
            pm0        <= '0;
            pm1        <= '0;
            pm2        <= '0;
            pm3        <= '0;
            best_state <= '0;
            sym_cnt    <= '0;
        end else if (accept) begin
            pm_q       <= norm;
            out_valid  <= 1'b1;
            dec        <= dec_nxt;
            pm0        <= norm[0];
            pm1        <= norm[1];
            pm2        <= norm[2];
            pm3        <= norm[3];
            best_state <= best_nxt;
            sym_cnt    <= start ? CNT_W'(1) : sym_cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_acs_unit.sv
// tb_acs_unit: directed checks of acs_unit metrics, decisions, handshake, reset and decoding
module tb_acs_unit;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [1:0]  bm00 = '0, bm01 = '0, bm10 = '0, bm11 = '0;
    logic        in_ready, out_valid;
    logic [3:0]  dec;
    logic [5:0]  pm0, pm1, pm2, pm3;
    logic [1:0]  best_state;
    logic [15:0] sym_cnt;
    logic [23:0] pms;
    int          total = 0, passed = 0;

    assign pms = {pm0, pm1, pm2, pm3};

    always #5 clk = ~clk;

    acs_unit #(.PM_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .start(start),
        .bm00(bm00), .bm01(bm01), .bm10(bm10), .bm11(bm11),
        .out_valid(out_valid), .out_ready(out_ready), .dec(dec),
        .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
        .best_state(best_state), .sym_cnt(sym_cnt)
    );

    task automatic drive(input logic s, input logic [1:0] b00, b01, b10, b11);
        in_valid = 1'b1;
        start    = s;
        bm00     = b00;
        bm01     = b01;
        bm10     = b10;
        bm11     = b11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (sym_cnt !== 16'd0) $display("FAIL reset_sym_cnt got %0d exp 0", sym_cnt); else passed++;
        total++; if ({pms, dec, best_state} !== 30'd0) $display("FAIL reset_outputs got %h exp 0", {pms, dec, best_state}); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_first_symbol;
        drive(1'b1, 2'd0, 2'd1, 2'd1, 2'd2);
        total++; if (pms !== {6'd0, 6'd17, 6'd2, 6'd17}) $display("FAIL first_pm got %h exp %h", pms, {6'd0, 6'd17, 6'd2, 6'd17}); else passed++;
        total++; if (dec !== 4'b0000) $display("FAIL first_dec got %b exp 0000", dec); else passed++;
        total++; if (best_state !== 2'd0) $display("FAIL first_best got %0d exp 0", best_state); else passed++;
        total++; if (sym_cnt !== 16'd1) $display("FAIL first_cnt got %0d exp 1", sym_cnt); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", out_valid); else passed++;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", out_valid); else passed++;
        total++; if (pms !== {6'd0, 6'd17, 6'd2, 6'd17}) $display("FAIL drain_hold got %h exp %h", pms, {6'd0, 6'd17, 6'd2, 6'd17}); else passed++;
    endtask

    task automatic test_tie;
        drive(1'b1, 2'd1, 2'd1, 2'd1, 2'd1);
        total++; if ({pms, dec} !== {6'd0, 6'd16, 6'd0, 6'd16, 4'b0000}) $display("FAIL tie1 got %h exp %h", {pms, dec}, {6'd0, 6'd16, 6'd0, 6'd16, 4'b0000}); else passed++;
        drive(1'b0, 2'd1, 2'd1, 2'd1, 2'd1);
        total++; if ({pms, dec, sym_cnt} !== {24'd0, 4'b0000, 16'd2}) $display("FAIL tie2 got %h exp %h", {pms, dec, sym_cnt}, {24'd0, 4'b0000, 16'd2}); else passed++;
        drive(1'b0, 2'd1, 2'd1, 2'd1, 2'd1);
        total++; if ({pms, dec, best_state} !== {24'd0, 4'b0000, 2'd0}) $display("FAIL tie_equal got %h exp %h", {pms, dec, best_state}, {24'd0, 4'b0000, 2'd0}); else passed++;
        total++; if (sym_cnt !== 16'd3) $display("FAIL tie_cnt got %0d exp 3", sym_cnt); else passed++;
    endtask

    task automatic test_decisions;
        drive(1'b0, 2'd0, 2'd1, 2'd2, 2'd2);
        total++; if (pms !== {6'd0, 6'd1, 6'd0, 6'd1}) $display("FAIL dec1_pm got %h exp %h", pms, {6'd0, 6'd1, 6'd0, 6'd1}); else passed++;
        total++; if (dec !== 4'b0110) $display("FAIL dec1_dec got %b exp 0110", dec); else passed++;
        total++; if (best_state !== 2'd0) $display("FAIL dec1_best got %0d exp 0", best_state); else passed++;
        drive(1'b0, 2'd2, 2'd0, 2'd2, 2'd2);
        total++; if (pms !== {6'd2, 6'd1, 6'd2, 6'd0}) $display("FAIL dec2_pm got %h exp %h", pms, {6'd2, 6'd1, 6'd2, 6'd0}); else passed++;
        total++; if (dec !== 4'b0010) $display("FAIL dec2_dec got %b exp 0010", dec); else passed++;
        total++; if (best_state !== 2'd3) $display("FAIL dec2_best got %0d exp 3", best_state); else passed++;
        total++; if (sym_cnt !== 16'd5) $display("FAIL dec2_cnt got %0d exp 5", sym_cnt); else passed++;
    endtask

    // Metrics near the top of the range cannot arise from legal inputs, so the register is forced.
    // Old pm0..pm2 = 63, pm3 = 0: predecessor 3 (metric 0) wins next states 1 and 3.
    task automatic test_saturation;
        force dut.pm_q = {6'd0, 6'd63, 6'd63, 6'd63};
        drive(1'b0, 2'd2, 2'd2, 2'd2, 2'd2);
        release dut.pm_q;
        total++; if (pms !== {6'd61, 6'd0, 6'd61, 6'd0}) $display("FAIL sat_pm got %h exp %h", pms, {6'd61, 6'd0, 6'd61, 6'd0}); else passed++;
        total++; if (dec !== 4'b1010) $display("FAIL sat_dec got %b exp 1010", dec); else passed++;
        total++; if (best_state !== 2'd1) $display("FAIL sat_best got %0d exp 1", best_state); else passed++;
    endtask

    task automatic test_backpressure;
        logic [23:0] exp_pm [3] = '{{6'd0, 6'd2, 6'd0, 6'd2}, 24'd0, 24'd0};
        drive(1'b1, 2'd0, 2'd1, 2'd1, 2'd2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bm00 = 2'd1; bm01 = 2'd1; bm10 = 2'd1; bm11 = 2'd1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_ready got %b exp 0", in_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({in_ready, out_valid, sym_cnt, pms} !== {1'b0, 1'b1, 16'd1, 6'd0, 6'd17, 6'd2, 6'd17})
                $display("FAIL bp_hold%0d got %h exp %h", i, {in_ready, out_valid, sym_cnt, pms}, {1'b0, 1'b1, 16'd1, 6'd0, 6'd17, 6'd2, 6'd17});
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", in_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, sym_cnt, pms} !== {1'b1, 16'(i + 2), exp_pm[i]})
                $display("FAIL bp_stream%0d got %h exp %h", i, {out_valid, sym_cnt, pms}, {1'b1, 16'(i + 2), exp_pm[i]});
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_viterbi;
        logic [19:0] msg = 20'h0B3A6;
        logic [19:0] got;
        logic [3:0]  dtab [20];
        logic [1:0]  s, r, st;
        logic        u;
        s = 2'd0;
        for (int t = 0; t < 20; t++) begin
            u = msg[t];
            r = {u ^ s[1] ^ s[0], u ^ s[0]};
            s = {u, s[1]};
            if (t == 4) r = r ^ 2'b10;
            drive(t == 0, {1'b0, r[1]} + {1'b0, r[0]}, {1'b0, r[1]} + {1'b0, ~r[0]},
                          {1'b0, ~r[1]} + {1'b0, r[0]}, {1'b0, ~r[1]} + {1'b0, ~r[0]});
            dtab[t] = dec;
        end
        total++; if (sym_cnt !== 16'd20) $display("FAIL vit_cnt got %0d exp 20", sym_cnt); else passed++;
        total++; if (best_state !== 2'd0) $display("FAIL vit_best got %0d exp 0", best_state); else passed++;
        st = best_state;
        for (int t = 19; t >= 0; t--) begin
            got[t] = st[1];
            st = {st[0], dtab[t][st]};
        end
        total++; if (got !== msg) $display("FAIL vit_decode got %h exp %h", got, msg); else passed++;
    endtask

    task automatic test_midframe_reset;
        drive(1'b1, 2'd1, 2'd1, 2'd1, 2'd1);
        drive(1'b0, 2'd1, 2'd1, 2'd1, 2'd1);
        rst_n = 1'b0;
        #1;
        total++; if ({out_valid, in_ready, sym_cnt} !== {1'b0, 1'b1, 16'd0}) $display("FAIL mid_rst_ctl got %h exp %h", {out_valid, in_ready, sym_cnt}, {1'b0, 1'b1, 16'd0}); else passed++;
        total++; if ({pms, dec, best_state} !== 30'd0) $display("FAIL mid_rst_out got %h exp 0", {pms, dec, best_state}); else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 2'd1, 2'd1, 2'd2);
        total++; if (pms !== {6'd0, 6'd17, 6'd2, 6'd17}) $display("FAIL mid_first_pm got %h exp %h", pms, {6'd0, 6'd17, 6'd2, 6'd17}); else passed++;
        total++; if ({dec, best_state, sym_cnt} !== {4'b0000, 2'd0, 16'd1}) $display("FAIL mid_first_misc got %h exp %h", {dec, best_state, sym_cnt}, {4'b0000, 2'd0, 16'd1}); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_symbol();
        test_tie();
        test_decisions();
        test_saturation();
        test_backpressure();
        test_viterbi();
        test_midframe_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
